// File: rtl/pw_decoder_pkg.sv
// Shared types for the pulse-width decoder and gamma-phase tooling.
// Defining PW_DECODER_PULSE_ERR_EN adds a second-pulse error flag to pw_result_t.
package pw_pkg;

    localparam int PW_GCW_DEFAULT = 16;

    function automatic int pw_cw(input int gcw);
        return $clog2(gcw + 1);
    endfunction

    localparam int PW_CW = pw_cw(PW_GCW_DEFAULT);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        HIGH,
        DONE
    } pw_state_t;

    // Field widths follow the package default cycle length.
    typedef struct packed {
        logic [PW_CW-1:0] onset;
        logic [PW_CW-1:0] width;
`ifdef PW_DECODER_PULSE_ERR_EN
        logic             err;
`endif
    } pw_result_t;

endpackage

// File: rtl/pw_decoder_gamma_phase_ctr.sv
// Saturating gamma-cycle phase counter, restarted by the gstart strobe.
// phase is the phase of the current sample; phase_ok drops once the counter is stuck at its last value.
module gamma_phase_ctr #(
    parameter int GAMMA_CYCLE_WIDTH = 16,
    parameter int CW                = 5
) (
    input  logic          aclk,
    input  logic          grst_n,
    input  logic          gstart,
    output logic [CW-1:0] phase,
    output logic          phase_ok
);

    localparam logic [CW-1:0] LAST = CW'(GAMMA_CYCLE_WIDTH - 1);

    logic [CW-1:0] phase_q;
    logic [CW-1:0] phase_d;

    always_comb begin
        phase_ok = 1'b1;
        if (gstart) begin
            phase_d = '0;
        end else if (phase_q == LAST) begin
            // Already counted the last phase: a late gstart leaves samples without a phase.
            phase_d  = LAST;
            phase_ok = 1'b0;
        end else begin
            phase_d = phase_q + 1'b1;
        end
    end

    always_ff @(posedge aclk or negedge grst_n) begin
        if (!grst_n) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

    assign phase = phase_d;

endmodule

// File: rtl/pw_decoder.sv
// Converts one pulse-width-coded wire into per-gamma-cycle onset/width with a valid/ready holding register.
// Optional macro PW_DECODER_PULSE_ERR_EN adds out_err flagging a second pulse within a gamma cycle.
module pw_decoder
    import pw_pkg::*;
#(
    parameter int GAMMA_CYCLE_WIDTH = PW_GCW_DEFAULT,
    parameter int CW                = pw_cw(GAMMA_CYCLE_WIDTH)
) (
    input  logic          aclk,
    input  logic          grst_n,
    input  logic          gstart,
    input  logic          pin,
    output logic [CW-1:0] out_onset,
    output logic [CW-1:0] out_width,
    output logic          out_valid,
    input  logic          out_ready,
`ifdef PW_DECODER_PULSE_ERR_EN
    output logic          out_err,
`endif
    output logic          out_drop
);

    localparam logic [CW-1:0] NO_SPIKE = CW'(GAMMA_CYCLE_WIDTH);

    logic [CW-1:0] phase;
    logic          phase_ok;

    gamma_phase_ctr #(
        .GAMMA_CYCLE_WIDTH (GAMMA_CYCLE_WIDTH),
        .CW                (CW)
    ) u_phase (
        .aclk     (aclk),
        .grst_n   (grst_n),
        .gstart   (gstart),
        .phase    (phase),
        .phase_ok (phase_ok)
    );

    pw_state_t  state_q;
    logic [CW-1:0] onset_q;
    logic [CW-1:0] count_q;
    pw_result_t res_q;
    pw_result_t fin_d;
    logic       out_valid_q;
    logic       out_drop_q;
`ifdef PW_DECODER_PULSE_ERR_EN
    logic       err_q;
    logic       pin_q;
`endif

    logic load;
    assign load = gstart && (state_q != IDLE);

    always_comb begin
        fin_d = '0;
        if (state_q == WAIT) begin
            fin_d.onset = NO_SPIKE;
            fin_d.width = '0;
        end else begin
            fin_d.onset = onset_q;
            fin_d.width = count_q;
        end
`ifdef PW_DECODER_PULSE_ERR_EN
        fin_d.err = err_q;
`endif
    end

    always_ff @(posedge aclk or negedge grst_n) begin
        if (!grst_n) begin
            state_q     <= IDLE;
            onset_q     <= NO_SPIKE;
            count_q     <= '0;
            res_q       <= '0;
            res_q.onset <= NO_SPIKE;
            out_valid_q <= 1'b0;
            out_drop_q  <= 1'b0;
`ifdef PW_DECODER_PULSE_ERR_EN
            err_q       <= 1'b0;
            pin_q       <= 1'b0;
`endif
        end else begin
`ifdef PW_DECODER_PULSE_ERR_EN
            pin_q <= pin;
`endif
            out_drop_q <= 1'b0;
            if (load) begin
                res_q       <= fin_d;
                out_valid_q <= 1'b1;
                out_drop_q  <= out_valid_q && !out_ready;
            end else if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end

            if (gstart) begin
                // The boundary sample belongs to the new cycle; a spanning pulse restarts at onset 0.
                if (state_q != IDLE && pin) begin
                    state_q <= HIGH;
                    onset_q <= '0;
                    count_q <= CW'(1);
                end else begin
                    state_q <= WAIT;
                    onset_q <= NO_SPIKE;
                    count_q <= '0;
                end
`ifdef PW_DECODER_PULSE_ERR_EN
                err_q <= 1'b0;
`endif
            end else if (phase_ok) begin
                case (state_q)
                    WAIT: begin
                        if (pin) begin
                            state_q <= HIGH;
                            onset_q <= phase;
                            count_q <= CW'(1);
                        end
                    end
                    HIGH: begin
                        if (pin) begin
                            count_q <= count_q + 1'b1;
                        end else begin
                            state_q <= DONE;
                        end
                    end
`ifdef PW_DECODER_PULSE_ERR_EN
                    DONE: begin
                        if (pin && !pin_q) begin
                            err_q <= 1'b1;
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    assign out_onset = res_q.onset;
    assign out_width = res_q.width;
    assign out_valid = out_valid_q;
    assign out_drop  = out_drop_q;
`ifdef PW_DECODER_PULSE_ERR_EN
    assign out_err   = res_q.err;
`endif

endmodule

// File: tb/tb_pw_decoder.sv
// Directed bench for pw_decoder: per-cycle pin patterns feed a reference model whose results are queued and
// compared when the DUT loads its output register.
module tb_pw_decoder;

    logic       aclk = 1'b0;
    logic       grst_n;
    logic       gstart;
    logic       pin;
    logic       out_ready;
    logic       out_valid;
    logic       out_drop;
    logic [4:0] out_onset;
    logic [4:0] out_width;
`ifdef PW_DECODER_PULSE_ERR_EN
    logic       out_err;
`endif

    always #5 aclk = ~aclk;

    pw_decoder dut (
        .aclk      (aclk),
        .grst_n    (grst_n),
        .gstart    (gstart),
        .pin       (pin),
        .out_onset (out_onset),
        .out_width (out_width),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef PW_DECODER_PULSE_ERR_EN
        .out_err   (out_err),
`endif
        .out_drop  (out_drop)
    );

    typedef struct packed {
        logic [4:0] onset;
        logic [4:0] width;
        logic       err;
    } exp_t;

    exp_t        sb[$];
    exp_t        held;
    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [15:0] cur_pat;
    int          idx;
    bit          started;
    bit          exp_valid;

    // Reference: first high sample, run length of that pulse, any later rising edge in the cycle.
    function automatic exp_t model(input logic [15:0] p);
        exp_t m;
        int   i;
        m.onset = 5'd16;
        m.width = 5'd0;
        m.err   = 1'b0;
        i = 0;
        while (i < 16 && !p[i]) i++;
        if (i < 16) begin
            m.onset = 5'(i);
            while (i < 16 && p[i]) begin
                m.width = m.width + 5'd1;
                i++;
            end
            for (int j = i + 1; j < 16; j++)
                if (p[j] && !p[j-1]) m.err = 1'b1;
        end
        return m;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic check_outputs(input bit exp_drop);
        check("out_valid", 32'(out_valid), 32'(exp_valid));
        check("out_drop",  32'(out_drop),  32'(exp_drop));
        check("out_onset", 32'(out_onset), 32'(held.onset));
        check("out_width", 32'(out_width), 32'(held.width));
`ifdef PW_DECODER_PULSE_ERR_EN
        check("out_err",   32'(out_err),   32'(held.err));
`endif
    endtask

    task automatic tick(input bit g, input bit p);
        bit loaded;
        bit exp_drop;
        loaded   = 1'b0;
        exp_drop = 1'b0;
        gstart   = g;
        pin      = p;
        if (g) begin
            if (started) begin
                sb.push_back(model(cur_pat));
                exp_drop  = exp_valid && !out_ready;
                exp_valid = 1'b1;
                loaded    = 1'b1;
            end else if (exp_valid && out_ready) begin
                exp_valid = 1'b0;
            end
            cur_pat = '0;
            if (started) cur_pat[0] = p;
            started = 1'b1;
            idx     = 0;
        end else begin
            if (exp_valid && out_ready) exp_valid = 1'b0;
            idx++;
            if (started && idx < 16) cur_pat[idx] = p;
        end
        @(posedge aclk);
        #1;
        if (loaded) begin
            held = sb.pop_front();
            $display("result load: expect onset=%0d width=%0d err=%0d drop=%0d | got onset=%0d width=%0d drop=%0d",
                     held.onset, held.width, held.err, exp_drop, out_onset, out_width, out_drop);
        end
        check_outputs(exp_drop);
    endtask

    task automatic gamma(input logic [15:0] pat);
        for (int ph = 0; ph < 16; ph++) tick(ph == 0, pat[ph]);
    endtask

    task automatic bench_reset_state();
        sb.delete();
        exp_valid   = 1'b0;
        started     = 1'b0;
        idx         = 0;
        cur_pat     = '0;
        held.onset  = 5'd16;
        held.width  = 5'd0;
        held.err    = 1'b0;
    endtask

    initial begin
        grst_n    = 1'b0;
        gstart    = 1'b0;
        pin       = 1'b0;
        out_ready = 1'b1;
        bench_reset_state();
        repeat (2) @(posedge aclk);
        #1;
        check_outputs(1'b0);
        grst_n = 1'b1;

        // Partial cycle before first gstart, then no-pulse, pulse 2-9, boundary span 14-19.
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b0);
        gamma(16'h0000);
        gamma(16'h03FC);
        gamma(16'hC000);
        gamma(16'h000F);
        gamma(16'h0000);

        // Backpressure across two loads, then accept on the load edge.
        out_ready = 1'b0;
        gamma(16'h0010);
        gamma(16'h0100);
        gamma(16'h0E00);
        out_ready = 1'b1;
        gamma(16'h0000);

        // Second pulse in a cycle, then a clean cycle.
        gamma(16'h018E);
        gamma(16'h0030);
        gamma(16'h0000);

        // Reset at phase 5 with a result pending and a pulse in progress.
        out_ready = 1'b0;
        gamma(16'h00F0);
        tick(1'b1, 1'b0);
        for (int ph = 1; ph < 5; ph++) tick(1'b0, (ph >= 3));
        pin = 1'b1;
        #1;
        grst_n = 1'b0;
        bench_reset_state();
        #1;
        check_outputs(1'b0);
        repeat (2) @(posedge aclk);
        #1;
        check_outputs(1'b0);
        grst_n    = 1'b1;
        pin       = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) tick(1'b0, 1'b1);
        gamma(16'h0000);
        gamma(16'h0006);
        gamma(16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
